// File: rtl/clk_switch_ctrl.sv
// Sequences oscillator power-up, glitch-safe clock select handover and power-down,
// with sticky timeout / oscillator-loss error flags.
module clk_switch_ctrl #(
   parameter int STARTUP_CYCLES = 1024,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int GUARD_CYCLES   = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic osc_req,
   input  logic osc_ok,
   input  logic err_clr,
   output logic osc_pwr_en,
   output logic sel_clk1,
   output logic on_osc,
   output logic busy,
   output logic err_timeout,
   output logic err_lost
);

   localparam int MAX_A   = (STARTUP_CYCLES > TIMEOUT_CYCLES) ? STARTUP_CYCLES : TIMEOUT_CYCLES;
   localparam int MAX_CYC = (MAX_A > GUARD_CYCLES) ? MAX_A : GUARD_CYCLES;
   localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CW-1:0] STARTUP_LD = CW'(STARTUP_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LD = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] GUARD_LD   = CW'(GUARD_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, WARMUP, CHECK, SW_ON, RUN, SW_OFF} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          ok_meta;
   logic          osc_ok_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ok_meta  <= 1'b0;
         osc_ok_s <= 1'b0;
      end else begin
         ok_meta  <= osc_ok;
         osc_ok_s <= ok_meta;
      end
   end

   // Outputs are assigned alongside each transition so they change on the same edge as the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         osc_pwr_en  <= 1'b0;
         sel_clk1    <= 1'b0;
         on_osc      <= 1'b0;
         busy        <= 1'b0;
         err_timeout <= 1'b0;
         err_lost    <= 1'b0;
      end else begin
         if (err_clr) begin
            err_timeout <= 1'b0;
            err_lost    <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (osc_req && !err_timeout && !err_lost) begin
                  state      <= WARMUP;
                  cnt        <= STARTUP_LD;
                  osc_pwr_en <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            WARMUP: begin
               if (!osc_req) begin
                  state      <= IDLE;
                  osc_pwr_en <= 1'b0;
                  busy       <= 1'b0;
               end else if (cnt == '0) begin
                  state <= CHECK;
                  cnt   <= TIMEOUT_LD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            CHECK: begin
               if (!osc_req) begin
                  state      <= IDLE;
                  osc_pwr_en <= 1'b0;
                  busy       <= 1'b0;
               end else if (osc_ok_s) begin
                  state    <= SW_ON;
                  cnt      <= GUARD_LD;
                  sel_clk1 <= 1'b1;
               end else if (cnt == '0) begin
                  state       <= IDLE;
                  osc_pwr_en  <= 1'b0;
                  busy        <= 1'b0;
                  err_timeout <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            SW_ON, RUN: begin
               // Oscillator loss and request drop share the exit; loss also latches the error.
               if (!osc_ok_s || !osc_req) begin
                  state    <= SW_OFF;
                  cnt      <= GUARD_LD;
                  sel_clk1 <= 1'b0;
                  on_osc   <= 1'b0;
                  busy     <= 1'b1;
                  if (!osc_ok_s) begin
                     err_lost <= 1'b1;
                  end
               end else if (state == SW_ON) begin
                  if (cnt == '0) begin
                     state  <= RUN;
                     on_osc <= 1'b1;
                     busy   <= 1'b0;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
            end
            SW_OFF: begin
               if (cnt == '0) begin
                  state      <= IDLE;
                  osc_pwr_en <= 1'b0;
                  busy       <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state      <= IDLE;
               cnt        <= '0;
               osc_pwr_en <= 1'b0;
               sel_clk1   <= 1'b0;
               on_osc     <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed and randomized bench for clk_switch_ctrl, checked against a phase/elapsed-time
// reference model plus explicit timing expectations.
module tb_clk_switch_ctrl;

   localparam int S = 4;
   localparam int T = 16;
   localparam int G = 2;

   logic clk;
   logic rst_n;
   logic osc_req;
   logic osc_ok;
   logic err_clr;
   logic osc_pwr_en;
   logic sel_clk1;
   logic on_osc;
   logic busy;
   logic err_timeout;
   logic err_lost;

   int errors = 0;
   int checks = 0;

   clk_switch_ctrl #(
      .STARTUP_CYCLES(S),
      .TIMEOUT_CYCLES(T),
      .GUARD_CYCLES(G)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .osc_req(osc_req),
      .osc_ok(osc_ok),
      .err_clr(err_clr),
      .osc_pwr_en(osc_pwr_en),
      .sel_clk1(sel_clk1),
      .on_osc(on_osc),
      .busy(busy),
      .err_timeout(err_timeout),
      .err_lost(err_lost)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: named phase, cycles spent in it, and a 2-deep history of osc_ok samples.
   string mPhase;
   int    mAge;
   bit    mErrT;
   bit    mErrL;
   bit    okHist[$];

   function automatic void modelReset();
      mPhase = "idle";
      mAge   = 0;
      mErrT  = 1'b0;
      mErrL  = 1'b0;
      okHist = {1'b0, 1'b0};
   endfunction

   function automatic void modelStep(input bit req, input bit ok, input bit clr);
      bit    okS;
      bit    setT;
      bit    setL;
      string nxt;
      okS  = okHist[0];
      void'(okHist.pop_front());
      okHist.push_back(ok);
      nxt  = mPhase;
      setT = 1'b0;
      setL = 1'b0;
      if (mPhase == "idle") begin
         if (req && !mErrT && !mErrL) nxt = "warmup";
      end else if (mPhase == "warmup") begin
         if (!req) nxt = "idle";
         else if (mAge == S - 1) nxt = "check";
      end else if (mPhase == "check") begin
         if (!req) nxt = "idle";
         else if (okS) nxt = "sw_on";
         else if (mAge == T - 1) begin
            nxt  = "idle";
            setT = 1'b1;
         end
      end else if (mPhase == "sw_on" || mPhase == "run") begin
         if (!okS) begin
            nxt  = "sw_off";
            setL = 1'b1;
         end else if (!req) nxt = "sw_off";
         else if (mPhase == "sw_on" && mAge == G - 1) nxt = "run";
      end else if (mPhase == "sw_off") begin
         if (mAge == G - 1) nxt = "idle";
      end
      mErrT  = setT | (mErrT & !clr);
      mErrL  = setL | (mErrL & !clr);
      mAge   = (nxt == mPhase) ? mAge + 1 : 0;
      mPhase = nxt;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".osc_pwr_en"}, 32'(osc_pwr_en), 32'(mPhase != "idle"));
      checkOutput({tag, ".sel_clk1"}, 32'(sel_clk1), 32'(mPhase == "sw_on" || mPhase == "run"));
      checkOutput({tag, ".on_osc"}, 32'(on_osc), 32'(mPhase == "run"));
      checkOutput({tag, ".busy"}, 32'(busy), 32'(mPhase != "idle" && mPhase != "run"));
      checkOutput({tag, ".err_timeout"}, 32'(err_timeout), 32'(mErrT));
      checkOutput({tag, ".err_lost"}, 32'(err_lost), 32'(mErrL));
   endtask

   // One clock cycle: drive inputs, let the edge happen, advance the model, check 1 time unit later.
   task automatic applyStimulus(input bit req, input bit ok, input bit clr, input string tag);
      osc_req = req;
      osc_ok  = ok;
      err_clr = clr;
      @(posedge clk);
      modelStep(req, ok, clr);
      #1;
      checkAll(tag);
   endtask

   task automatic checkZero(input string tag);
      checkOutput({tag, ".osc_pwr_en"}, 32'(osc_pwr_en), 32'd0);
      checkOutput({tag, ".sel_clk1"}, 32'(sel_clk1), 32'd0);
      checkOutput({tag, ".on_osc"}, 32'(on_osc), 32'd0);
      checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
      checkOutput({tag, ".err_timeout"}, 32'(err_timeout), 32'd0);
      checkOutput({tag, ".err_lost"}, 32'(err_lost), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int firstPwr;
      int firstSel;
      int firstOn;
      bit req;
      bit ok;
      bit clr;

      rst_n   = 1'b0;
      osc_req = 1'b0;
      osc_ok  = 1'b0;
      err_clr = 1'b0;
      modelReset();
      repeat (3) @(posedge clk);
      #1;
      checkZero("reset");
      rst_n = 1'b1;

      $display("[TB] normal switch-on");
      firstPwr = 0;
      firstSel = 0;
      firstOn  = 0;
      for (int k = 1; k <= 12; k++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, "on");
         if (firstPwr == 0 && osc_pwr_en === 1'b1) firstPwr = k;
         if (firstSel == 0 && sel_clk1 === 1'b1) firstSel = k;
         if (firstOn == 0 && on_osc === 1'b1) firstOn = k;
      end
      checkOutput("on.pwr_cycle", 32'(firstPwr), 32'd1);
      checkOutput("on.sel_cycle", 32'(firstSel), 32'd1 + 32'(S) + 32'd1);
      checkOutput("on.run_cycle", 32'(firstOn), 32'd1 + 32'(S) + 32'd1 + 32'(G));

      $display("[TB] normal switch-off");
      for (int k = 1; k <= 5; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, "off");
         checkOutput("off.sel", 32'(sel_clk1), 32'd0);
         checkOutput("off.pwr_hold", 32'(osc_pwr_en), 32'(k <= G));
         checkOutput("off.busy", 32'(busy), 32'(k <= G));
      end

      $display("[TB] warm-up timeout");
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, "pre_to");
      for (int k = 1; k <= 26; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, "to");
         checkOutput("to.err_timeout", 32'(err_timeout), 32'(k >= S + T + 1));
         checkOutput("to.pwr", 32'(osc_pwr_en), 32'(k <= S + T));
      end
      applyStimulus(1'b1, 1'b0, 1'b1, "to_clr");
      checkOutput("to_clr.err_timeout", 32'(err_timeout), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, "re_enter");
      checkOutput("re_enter.pwr", 32'(osc_pwr_en), 32'd1);

      $display("[TB] abort during warm-up");
      applyStimulus(1'b1, 1'b0, 1'b0, "warm");
      applyStimulus(1'b0, 1'b0, 1'b0, "abort");
      checkZero("abort");

      $display("[TB] oscillator loss in RUN");
      repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, "pre_loss");
      repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, "to_run");
      checkOutput("loss.in_run", 32'(on_osc), 32'd1);
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(1'b1, 1'b0, (k == 3), "loss");
         checkOutput("loss.err_lost", 32'(err_lost), 32'(k >= 3));
         checkOutput("loss.sel", 32'(sel_clk1), 32'(k < 3));
      end
      repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, "locked");
      checkOutput("locked.pwr", 32'(osc_pwr_en), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b1, "loss_clr");

      $display("[TB] async reset in RUN");
      repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, "to_run2");
      checkOutput("rst.in_run", 32'(sel_clk1), 32'd1);
      #3;
      rst_n = 1'b0;
      modelReset();
      #1;
      checkZero("async_rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      $display("[TB] randomized traffic");
      req = 1'b0;
      ok  = 1'b1;
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 24) == 0) req = !req;
         if (ok) begin
            if ($urandom_range(0, 79) == 0) ok = 1'b0;
         end else begin
            if ($urandom_range(0, 5) == 0) ok = 1'b1;
         end
         clr = ($urandom_range(0, 39) == 0);
         applyStimulus(req, ok, clr, "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/clk_switch_ctrl.md
CLK_SWITCH_CTRL -- requirements
Module: clk_switch_ctrl

Interface
REQ-001 SHALL have parameter STARTUP_CYCLES, default 1024: oscillator warm-up wait, in clk cycles, after power-on.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096: maximum clk cycles to wait for osc_ok after warm-up.
REQ-003 SHALL have parameter GUARD_CYCLES, default 8: hold time after each sel_clk1 change, covering the downstream switch's 3-flop handover on both clocks.
REQ-004 SHALL have port clk  input  1  always-running RC clock; the only clock of this block.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port osc_req  input  1  level request, synchronous to clk: 1 = run from oscillator.
REQ-007 SHALL have port osc_ok  input  1  asynchronous oscillator-good indication from the analog detector.
REQ-008 SHALL have port err_clr  input  1  synchronous single-cycle pulse that clears the sticky error flags.
REQ-009 SHALL have port osc_pwr_en  output  1  oscillator power enable.
REQ-010 SHALL have port sel_clk1  output  1  select to the clock switch: 1 = oscillator, 0 = RC.
REQ-011 SHALL have port on_osc  output  1  status: switch complete, running on the oscillator.
REQ-012 SHALL have port busy  output  1  1 in any state other than IDLE and RUN.
REQ-013 SHALL have port err_timeout  output  1  sticky: osc_ok not seen within TIMEOUT_CYCLES.
REQ-014 SHALL have port err_lost  output  1  sticky: osc_ok dropped while in SW_ON or RUN.

Function
REQ-015 osc_ok SHALL pass through a 2-flop synchronizer (osc_ok_s); all decisions SHALL use only osc_ok_s.
REQ-016 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-017 SHALL implement an FSM with states IDLE, WARMUP, CHECK, SW_ON, RUN, SW_OFF, plus one shared down-counter sized to the largest parameter.
REQ-018 IDLE: osc_pwr_en=0, sel_clk1=0; if osc_req=1 and both error flags are 0 -> WARMUP, counter loaded with STARTUP_CYCLES-1.
REQ-019 WARMUP: osc_pwr_en=1; the counter decrements each cycle; at 0 -> CHECK, counter loaded with TIMEOUT_CYCLES-1.
REQ-020 CHECK: osc_ok_s=1 -> SW_ON, counter loaded with GUARD_CYCLES-1; counter at 0 with osc_ok_s=0 -> set err_timeout, go to IDLE (power off).
REQ-021 SW_ON: sel_clk1=1; at counter 0 -> RUN.
REQ-022 RUN: on_osc=1, sel_clk1=1, osc_pwr_en=1; stays in RUN while osc_req=1 and osc_ok_s=1.
REQ-023 RUN or SW_ON with osc_req=0 -> SW_OFF, counter loaded with GUARD_CYCLES-1.
REQ-024 RUN or SW_ON with osc_ok_s=0 -> set err_lost and go to SW_OFF; osc_ok_s loss SHALL take priority over osc_req when both occur in the same cycle.
REQ-025 SW_OFF: sel_clk1=0, osc_pwr_en stays 1, on_osc=0; at counter 0 -> IDLE. osc_pwr_en SHALL NOT fall before the guard expires.
REQ-026 osc_req dropping in WARMUP or CHECK SHALL abort to IDLE on the next cycle, with no error set.
REQ-027 osc_req rising while in SW_OFF SHALL be ignored until IDLE is reached; re-entry then follows REQ-018.
REQ-028 Each state transition SHALL take effect on the clk edge after its condition is sampled; registered outputs SHALL change on that same edge.
REQ-029 err_clr SHALL clear both flags on the next edge; a set event in the same cycle SHALL win, leaving the flag at 1.
REQ-030 While any error flag is 1, the block SHALL remain in IDLE regardless of osc_req.

Reset
REQ-031 rst_n=0 SHALL asynchronously force IDLE, counter=0, synchronizer flops=0, and all outputs 0.
REQ-032 Reset asserted mid-operation, including RUN, SHALL drop sel_clk1 and osc_pwr_en at once; the downstream switch tolerates this.
REQ-033 After rst_n deasserts, the first FSM transition SHALL occur no earlier than the next rising clk edge.

Verification
REQ-034 Normal on: STARTUP=4, TIMEOUT=16, GUARD=2; osc_req=1, osc_ok=1 -> osc_pwr_en=1 one cycle after the request; sel_clk1=1 after 4 warm-up cycles plus 1 CHECK cycle (osc_ok_s already high); on_osc=1 two cycles later.
REQ-035 Normal off: from RUN, osc_req=0 -> sel_clk1=0 and on_osc=0 on the next edge; osc_pwr_en=0 after 2 more cycles; busy=1 throughout.
REQ-036 Timeout: osc_ok held 0 -> err_timeout=1 and osc_pwr_en=0 exactly 4+16 cycles after WARMUP entry; further osc_req is ignored until an err_clr pulse.
REQ-037 Loss: osc_ok drops in RUN -> err_lost=1 and sel_clk1=0 3 cycles later (2 sync + 1); same-cycle err_clr leaves err_lost=1.
REQ-038 Abort/reset: osc_req drops mid-WARMUP -> IDLE with no error; rst_n pulsed in RUN -> all outputs 0 immediately, asynchronously.
